mmio_port_buffer: RTL
=====================

Name: mmio_port_buffer

Overview:
- Per-port peripheral-side buffer, directly downstream of the MMIO controller's port pair: consumes one port's two output words and its write-inform strobe, and supplies that port's two input words and its read-inform strobe.
- Decouples CPU-timed MMIO accesses from an external device using a TX FIFO (CPU to device) and an RX FIFO (device to CPU), each with a valid/ready handshake.
- One instance per port.

Parameters:
- TX_DEPTH_LOG2, 3, log2 of TX FIFO depth (8 entries of 32 bits).
- RX_DEPTH_LOG2, 3, log2 of RX FIFO depth (8 entries of 16 bits).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- inform_write  in  1  port write-inform from the MMIO controller; level, may stay high for many cycles.
- port_word_lo  in  16  port output word, even address (payload).
- port_word_hi  in  16  port output word, odd address (command/tag).
- inform_read  in  1  port read-inform from the MMIO controller; level.
- rd_word_lo  out  16  to controller port_d_in even: RX head data.
- rd_word_hi  out  16  to controller port_d_in odd: status word.
- tx_valid  out  1  TX head available to the device.
- tx_data  out  32  {hi, lo} of the TX head.
- tx_ready  in  1  device accepts the TX head.
- rx_valid  in  1  device offers an RX word.
- rx_data  in  16  RX word.
- rx_ready  out  1  buffer can accept an RX word.

Behaviour:
- Reset: both FIFOs empty, pointers 0, sticky flags 0. Outputs: tx_valid=0, tx_data=0, rx_ready=1, rd_word_lo=0, rd_word_hi=status of an empty buffer (0x0002).
- Strobe detection: inform_write and inform_read are registered. Only a rising edge (current=1, previous=0) is an event, so each access produces at most one push or pop.
- Write event, port_word_hi[15]=0: push {port_word_hi, port_word_lo} into TX, sampled in the event cycle.
  - If TX is full and no TX pop occurs that cycle: entry is dropped and sticky tx_drop is set.
- Write event, port_word_hi[15]=1: command. No push. Bit0=1 clears tx_drop and rx_ovf. Bit1=1 flushes both FIFOs (pointers to 0).
- TX pop: tx_valid && tx_ready. tx_valid = TX not empty; tx_data = head entry (0 when empty). A push into an empty FIFO is visible on tx_valid the cycle after the event (1-cycle latency).
- Simultaneous TX push and pop when full: both succeed, count unchanged, no drop.
- Simultaneous TX push and pop when empty: push succeeds, pop is impossible (tx_valid=0).
- RX push: rx_valid && rx_ready, where rx_ready = RX not full.
  - rx_valid while full: word ignored, sticky rx_ovf set.
- Read event: pop RX head if RX not empty; no effect if empty.
  - rd_word_lo shows the RX head combinationally from the FIFO (0 when empty), so the CPU sees the head before the pop.
  - The next head appears the cycle after the event.
- Status rd_word_hi:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_nonempty
  - [3] tx_drop
  - [4] rx_ovf
  - [7:5] 0
  - [11:8] tx_count
  - [15:12] rx_count
  - Counts saturate in 4 bits; with default parameters a count reaches 8.
- Pointers: TX/RX_DEPTH_LOG2+1 bits each; the extra MSB distinguishes full from empty on wrap-around.
- Flush command concurrent with a pop or RX push: flush wins; the FIFO is empty next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required. Edge-detect registers clear to 0, so a strobe held high through deassertion counts as one event.

Test Plan:
- Reset, then hold inform_write high for 5 cycles with lo=0x1234, hi=0x0001, tx_ready=0 -> exactly one push; tx_valid=1 one cycle after the edge; tx_data=0x00011234; status[11:8]=1.
- 9 write events with hi=0x0000 and lo=1..9, tx_ready=0 -> status tx_full=1, tx_count=8, tx_drop=1. Then drain with tx_ready=1 -> tx_data order 1..8; tx_empty=1 afterwards.
- With TX full, issue a write event (lo=0xAAAA) in the same cycle as a pop -> no drop; the last entry read out is 0x0000AAAA.
- Device pushes 0x0055, 0x0066 -> rd_word_lo=0x0055, rx_count=2. Read event -> rd_word_lo=0x0066 next cycle. Two more read events -> rd_word_lo=0, rx_nonempty=0, no underflow.
- Fill RX with 8 words, then drive rx_valid again -> rx_ready=0, rx_ovf=1. Write command hi=0x8001 -> tx_drop and rx_ovf cleared; FIFO contents unchanged.
- Mid-traffic, assert rst_n=0 asynchronously between clock edges -> tx_valid=0, rd_word_hi=0x0002 immediately. Command hi=0x8002 with both FIFOs non-empty -> both empty next cycle.

Source files
------------

// File: rtl/mmio_port_buffer.sv
// Per-port MMIO buffer: TX FIFO (CPU->device) fed by write-inform edges, RX FIFO (device->CPU) drained by read-inform edges.
// Pushes visible one cycle after the event; RX head and status are registered-state only; rx_ready drops when RX is full.

module mmio_pb_fifo #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module mmio_port_buffer #(
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int RX_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inform_write,
    input  logic [15:0] port_word_lo,
    input  logic [15:0] port_word_hi,
    input  logic        inform_read,
    output logic [15:0] rd_word_lo,
    output logic [15:0] rd_word_hi,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready
);
    typedef struct packed {
        logic [3:0] rx_count;
        logic [3:0] tx_count;
        logic [2:0] rsvd;
        logic       rx_ovf;
        logic       tx_drop;
        logic       rx_nonempty;
        logic       tx_empty;
        logic       tx_full;
    } status_t;

    logic wr_prev_q, rd_prev_q;
    logic tx_drop_q, tx_drop_d;
    logic rx_ovf_q,  rx_ovf_d;

    logic wr_ev, rd_ev, is_cmd;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic clr_flags, flush;

    logic [31:0]            tx_head;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic                   tx_full, tx_empty;
    logic [15:0]            rx_head;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic                   rx_full, rx_empty;
    status_t                status;

    function automatic logic [3:0] sat4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

    // Level strobes from the controller: only the rising edge is an access.
    assign wr_ev  = inform_write && !wr_prev_q;
    assign rd_ev  = inform_read  && !rd_prev_q;
    assign is_cmd = port_word_hi[15];

    assign clr_flags = wr_ev && is_cmd && port_word_hi[0];
    assign flush     = wr_ev && is_cmd && port_word_hi[1];

    assign tx_push = wr_ev && !is_cmd;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && rx_ready;
    assign rx_pop  = rd_ev;

    mmio_pb_fifo #(.W(32), .AW(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (tx_push),
        .push_dat_i ({port_word_hi, port_word_lo}),
        .pop_i      (tx_pop),
        .flush_i    (flush),
        .head_o     (tx_head),
        .count_o    (tx_count),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    mmio_pb_fifo #(.W(16), .AW(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (rx_push),
        .push_dat_i (rx_data),
        .pop_i      (rx_pop),
        .flush_i    (flush),
        .head_o     (rx_head),
        .count_o    (rx_count),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    assign tx_valid   = !tx_empty;
    assign tx_data    = tx_head;
    assign rx_ready   = !rx_full;
    assign rd_word_lo = rx_head;

    // A fresh overflow/drop in the clearing cycle is kept rather than lost.
    always_comb begin
        tx_drop_d = tx_drop_q && !clr_flags;
        rx_ovf_d  = rx_ovf_q  && !clr_flags;
        if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;
        if (rx_valid && rx_full)           rx_ovf_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            tx_drop_q <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            wr_prev_q <= inform_write;
            rd_prev_q <= inform_read;
            tx_drop_q <= tx_drop_d;
            rx_ovf_q  <= rx_ovf_d;
        end
    end

    always_comb begin
        status             = '0;
        status.tx_full     = tx_full;
        status.tx_empty    = tx_empty;
        status.rx_nonempty = !rx_empty;
        status.tx_drop     = tx_drop_q;
        status.rx_ovf      = rx_ovf_q;
        status.tx_count    = sat4(32'(tx_count));
        status.rx_count    = sat4(32'(rx_count));
    end

    assign rd_word_hi = status;
endmodule
